// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// datapath nibble width and step-counter sizing.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold 0..n-1; a single-step operation still needs one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_fa4_mbit.sv
// Existing 4-bit multi-bit adder reused as the shared nibble datapath.
module fa4_mbit
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands plus carry-in one nibble per cycle, LSB first,
// through a single shared 4-bit adder, with a start/done handshake.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int N  = WIDTH / NIB_W;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    generate
        if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [NIB_W-1:0]  add_s;
    logic              add_co;
    logic [WIDTH-1:0]  sum_next;

    fa4_mbit u_fa4 (
        .a  (a_sh[NIB_W-1:0]),
        .b  (b_sh[NIB_W-1:0]),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    // New result nibble enters at the MSB end so the sum lines up after N steps.
    always_comb begin
        sum_next = (sum_sh >> NIB_W) | (WIDTH'(add_s) << (WIDTH - NIB_W));
    end

    // Controller FSM, operand/sum shift registers, carry, counter and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            co     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= ci;
                        sum_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    sum_sh <= sum_next;
                    carry  <= add_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= sum_next;
                        co    <= add_co;
                        state <= DONE;
                    end else begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
